// File: rtl/signal_combiner.sv
// Purpose: joins two signed stream lanes into one packed word (lane 2 high, lane 1 low), narrowing each lane;
//          saturating narrowing and clip counting when SIGNAL_COMBINER_SATURATE_EN is defined, plain truncation otherwise.
// Latency: one cycle from both lanes buffered to M_AXIS_tvalid; backpressure: one-entry buffer per lane, lane tready low while full and no join.
module signal_combiner #(
  parameter int ADC_DATA_WIDTH   = 16,
  parameter int AXIS_TDATA_WIDTH = 32  // must be 2*ADC_DATA_WIDTH
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT1_tdata,
  input  logic                        S_AXIS_PORT1_tvalid,
  output logic                        S_AXIS_PORT1_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT2_tdata,
  input  logic                        S_AXIS_PORT2_tvalid,
  output logic                        S_AXIS_PORT2_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [15:0]                 clip_count
);

  localparam int AW = ADC_DATA_WIDTH;
  localparam int TW = AXIS_TDATA_WIDTH;

  logic          full1, full2;
  logic [TW-1:0] buf1, buf2;
  logic          acc1, acc2;
  logic          join_en;
  logic [AW-1:0] nar1, nar2;

  // The join fires when both lanes hold a sample and the output register is free or being drained.
  assign join_en = full1 & full2 & (~M_AXIS_tvalid | M_AXIS_tready);

  // A full lane can still accept when the join empties it on the same edge, keeping one sample per cycle.
  assign S_AXIS_PORT1_tready = ~full1 | join_en;
  assign S_AXIS_PORT2_tready = ~full2 | join_en;
  assign acc1 = S_AXIS_PORT1_tvalid & S_AXIS_PORT1_tready;
  assign acc2 = S_AXIS_PORT2_tvalid & S_AXIS_PORT2_tready;

  // Lane 1 buffer: refill wins over the join's clear so a simultaneous accept is never lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full1 <= 1'b0;
      buf1  <= '0;
    end else if (acc1) begin
      full1 <= 1'b1;
      buf1  <= S_AXIS_PORT1_tdata;
    end else if (join_en) begin
      full1 <= 1'b0;
    end
  end

  // Lane 2 buffer: same behaviour as lane 1.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full2 <= 1'b0;
      buf2  <= '0;
    end else if (acc2) begin
      full2 <= 1'b1;
      buf2  <= S_AXIS_PORT2_tdata;
    end else if (join_en) begin
      full2 <= 1'b0;
    end
  end

`ifdef SIGNAL_COMBINER_SATURATE_EN
  // A value fits the narrow lane when every bit from the narrow sign bit upwards equals the wide sign bit.
  localparam int            HW      = TW - AW + 1;
  localparam logic [AW-1:0] POS_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] NEG_MIN = {1'b1, {(AW-1){1'b0}}};

  logic        clip1, clip2;
  logic [15:0] clip_cnt;

  // Lane 1 narrowing: clamp to the most positive/negative narrow value when out of range.
  always_comb begin
    nar1  = buf1[AW-1:0];
    clip1 = 1'b0;
    if (buf1[TW-1:AW-1] != {HW{buf1[TW-1]}}) begin
      clip1 = 1'b1;
      nar1  = buf1[TW-1] ? NEG_MIN : POS_MAX;
    end
  end

  // Lane 2 narrowing, independent of lane 1.
  always_comb begin
    nar2  = buf2[AW-1:0];
    clip2 = 1'b0;
    if (buf2[TW-1:AW-1] != {HW{buf2[TW-1]}}) begin
      clip2 = 1'b1;
      nar2  = buf2[TW-1] ? NEG_MIN : POS_MAX;
    end
  end

  // Count emitted words carrying any clipped lane; stick at all-ones rather than wrap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      clip_cnt <= '0;
    end else if (join_en && (clip1 || clip2) && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

  assign clip_count = clip_cnt;
`else
  // Truncation keeps only the low bits; the discarded upper bits are folded into a sink.
  logic unused_hi;

  assign nar1       = buf1[AW-1:0];
  assign nar2       = buf2[AW-1:0];
  assign unused_hi  = ^{buf1[TW-1:AW], buf2[TW-1:AW]};
  assign clip_count = 16'd0;
`endif

  // Output register: load on join, drop valid once drained without a replacement, hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
    end else if (join_en) begin
      M_AXIS_tvalid <= 1'b1;
      M_AXIS_tdata  <= {nar2, nar1};
    end else if (M_AXIS_tready) begin
      M_AXIS_tvalid <= 1'b0;
    end
  end

endmodule
